do_inv_round: RTL and testbench

Registered single round of the AES-128 inverse cipher (FIPS-197 straightforward decryption order). Each clock it applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns to a 128-bit state, in that order, using a supplied 128-bit round key. The decryption datapath instantiates it for rounds 1..9. The initial AddRoundKey and the final round, which has no InvMixColumns, sit outside this block.

---
 rtl/do_inv_round_if.sv | 8 +
 rtl/do_inv_round.sv | 64 ++++++
 tb/tb_do_inv_round.sv | 116 +++++++++++
 3 files changed

// File: rtl/do_inv_round_if.sv
// do_inv_round_if: round state/key in, registered round result out
interface do_inv_round_if;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  modport master(output data_in, output key_in, input data_out);
  modport slave(input data_in, input key_in, output data_out);
endinterface

// File: rtl/do_inv_round.sv
// do_inv_round: one registered AES-128 inverse cipher round
// (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module do_inv_round (
  input logic          clk,
  input logic          rst_n,
  do_inv_round_if.slave bus
);
  localparam logic [2047:0] inv_sbox_tbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return inv_sbox_tbl[2047-8*int'(x) -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction
  logic [127:0] w_sub;
  logic [127:0] w_ark;
  logic [127:0] w_mix;
  logic [127:0] r_q;
  assign w_ark = w_sub ^ bus.key_in;
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int row = i % 4;
    localparam int col = i / 4;
    // InvShiftRows folded into the S-box input selection
    localparam int src = row + 4 * ((col - row + 4) % 4);
    assign w_sub[127-8*i -: 8] = inv_sbox(bus.data_in[127-8*src -: 8]);
    assign w_mix[127-8*i -: 8] = me(w_ark[127-8*(4*col+row) -: 8])
                               ^ mb(w_ark[127-8*(4*col+(row+1)%4) -: 8])
                               ^ md(w_ark[127-8*(4*col+(row+2)%4) -: 8])
                               ^ m9(w_ark[127-8*(4*col+(row+3)%4) -: 8]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else        r_q <= w_mix;
  assign bus.data_out = r_q;
endmodule

// File: tb/tb_do_inv_round.sv
// tb_do_inv_round: checks do_inv_round against an arithmetic AES round model
module tb_do_inv_round;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] isb [256];
  logic [127:0] exp_q = '0;
  logic [127:0] held;
  logic [127:0] pat;
  int n_tests = 0;
  int n_fail = 0;
  do_inv_round_if bus();
  do_inv_round dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction
  // inverse S-box derived from the forward S-box definition (GF inverse + affine)
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
  end
  function automatic logic [127:0] model(input logic [127:0] dd, input logic [127:0] kk);
    logic [7:0] st [4][4];
    logic [7:0] a [4][4];
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = dd[127-8*(r+4*c) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = isb[st[r][(c-r+4)%4]] ^ kk[127-8*(r+4*c) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = gmul(8'h0e, a[r][c]) ^ gmul(8'h0b, a[(r+1)%4][c])
                              ^ gmul(8'h0d, a[(r+2)%4][c]) ^ gmul(8'h09, a[(r+3)%4][c]);
    return o;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %032h want %032h at %0t", name, act, want, $time);
    end
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(posedge clk or negedge rst_n)
    exp_q <= !rst_n ? 128'h0 : model(bus.data_in, bus.key_in);
  always @(negedge clk) chk("cycle", bus.data_out, exp_q);
  initial begin
    bus.data_in = rnd();
    bus.key_in = rnd();
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      bus.data_in = rnd();
      bus.key_in = rnd();
      chk("reset_hold", bus.data_out, 128'h0);
    end
    chk("model_sbox", model('0, '0), {16{8'h52}});
    chk("model_zero", model({16{8'h63}}, '0), 128'h0);
    chk("model_imc", model({16{8'h63}}, {4{32'h8e4da1bc}}), {4{32'hdb135345}});
    bus.data_in = '0;
    bus.key_in = '0;
    rst_n = 1'b1;
    chk("release_no_edge", bus.data_out, 128'h0);
    @(posedge clk); #1;
    chk("uniform_sbox", bus.data_out, {16{8'h52}});
    bus.data_in = {16{8'h63}};
    @(posedge clk); #1;
    chk("zero_path", bus.data_out, 128'h0);
    bus.key_in = {4{32'h8e4da1bc}};
    @(posedge clk); #1;
    chk("imc_vector", bus.data_out, {4{32'hdb135345}});
    pat = 128'h0123456789abcdef0123456789abcdef;
    bus.data_in = pat;
    bus.key_in = pat;
    @(posedge clk); #1;
    held = bus.data_out;
    chk("pattern_first", held, model(pat, pat));
    repeat (9) begin
      @(posedge clk); #1;
      chk("pattern_hold", bus.data_out, held);
    end
    for (int i = 0; i < 1000; i++) begin
      bus.data_in = rnd();
      bus.key_in = rnd();
      if (i == 500) begin
        #2 rst_n = 1'b0;
        #1 chk("async_clear", bus.data_out, 128'h0);
        @(posedge clk); #1;
        chk("reset_low", bus.data_out, 128'h0);
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
